// File: rtl/serial_pe_ctrl.sv
// serial_pe_ctrl: sequences one serial_pe through an N-element dot product from two SRAM read ports.
// Define SERIAL_PE_CTRL_RELU_EN to clamp negative results to zero at capture.
module serial_pe_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [ADDR_W-1:0] n_base,
    input  logic [ADDR_W-1:0] w_base,
    output logic              busy,
    output logic              n_rd_en,
    output logic [ADDR_W-1:0] n_rd_addr,
    input  logic [15:0]       n_rd_data,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [15:0]       w_rd_data,
    output logic [15:0]       pe_neuron,
    output logic [15:0]       pe_weight,
    output logic              pe_vld,
    output logic [1:0]        pe_ctl,
    input  logic [31:0]       pe_result,
    input  logic              pe_vld_o,
    output logic [31:0]       res_data,
    output logic              res_vld,
    input  logic              res_rdy
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic              rd_first;
    logic              rd_last;
    logic [31:0]       cap;
`ifdef SERIAL_PE_CTRL_RELU_EN
    assign cap = pe_result[31] ? '0 : pe_result;
`else
    assign cap = pe_result;
`endif
    assign w_rd_en   = n_rd_en;
    assign pe_neuron = n_rd_data;
    assign pe_weight = w_rd_data;
    // cnt holds the number of reads issued so far, including the one on the bus now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            rd_first  <= 1'b0;
            rd_last   <= 1'b0;
            n_rd_en   <= 1'b0;
            n_rd_addr <= '0;
            w_rd_addr <= '0;
            pe_vld    <= 1'b0;
            pe_ctl    <= 2'b00;
            res_data  <= '0;
            res_vld   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pe_vld <= n_rd_en;
            pe_ctl <= n_rd_en ? {rd_last, rd_first} : 2'b00;
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    len       <= vec_len;
                    cnt       <= LEN_W'(1);
                    n_rd_addr <= n_base;
                    w_rd_addr <= w_base;
                    rd_first  <= 1'b1;
                    rd_last   <= vec_len == LEN_W'(1);
                    if (vec_len == '0) begin
                        state    <= OUT;
                        res_data <= '0;
                        res_vld  <= 1'b1;
                    end else begin
                        state   <= FETCH;
                        n_rd_en <= 1'b1;
                    end
                end
                FETCH: if (cnt == len) begin
                    n_rd_en <= 1'b0;
                    state   <= DRAIN;
                end else begin
                    cnt       <= cnt + LEN_W'(1);
                    n_rd_addr <= n_rd_addr + ADDR_W'(1);
                    w_rd_addr <= w_rd_addr + ADDR_W'(1);
                    rd_first  <= 1'b0;
                    rd_last   <= cnt + LEN_W'(1) == len;
                end
                DRAIN: if (pe_vld_o) begin
                    res_data <= cap;
                    res_vld  <= 1'b1;
                    state    <= OUT;
                end
                OUT: if (res_rdy) begin
                    res_vld <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
